ternary_popcount_acc: RTL and testbench



---
 rtl/tpc_pkg.sv | 31 +++
 rtl/ternary_popcount_acc_popcount_tree.sv | 30 +++
 rtl/ternary_popcount_acc.sv | 175 +++++++++++++++++
 tb/tb_ternary_popcount_acc.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/tpc_pkg.sv
// Shared definitions for the ternary popcount accumulator.
// Widths derive from WIDTH/BEATS_W through the helper functions here.
package tpc_pkg;

    // Ceiling log2 for elaboration-time width derivation.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    // Per-beat count width: enough to hold 0..width.
    function automatic int cnt_w(input int width);
        return clog2(width + 1);
    endfunction

    // Signed accumulator width: full frame of +width or -width per beat.
    function automatic int acc_w(input int width, input int beats_w);
        return cnt_w(width) + beats_w + 1;
    endfunction

    typedef enum logic [1:0] {
        ACC   = 2'd0,
        FLUSH = 2'd1,
        HOLD  = 2'd2
    } state_e;

endpackage

// File: rtl/ternary_popcount_acc_popcount_tree.sv
// Exact popcount built as a recursive binary adder tree. Approximate
// variants can be swapped in later behind the same ports.
module popcount_tree
    import tpc_pkg::*;
#(
    parameter int WIDTH = 20
) (
    input  logic [WIDTH-1:0]        bits,
    output logic [cnt_w(WIDTH)-1:0] cnt
);

    generate
        if (WIDTH == 1) begin : g_leaf
            assign cnt = bits;
        end else begin : g_node
            localparam int WL = WIDTH / 2;
            localparam int WH = WIDTH - WL;
            localparam int CW = cnt_w(WIDTH);

            logic [cnt_w(WL)-1:0] lo_cnt;
            logic [cnt_w(WH)-1:0] hi_cnt;

            popcount_tree #(.WIDTH(WL)) u_lo (.bits(bits[WL-1:0]),     .cnt(lo_cnt));
            popcount_tree #(.WIDTH(WH)) u_hi (.bits(bits[WIDTH-1:WL]), .cnt(hi_cnt));

            assign cnt = CW'(lo_cnt) + CW'(hi_cnt);
        end
    endgenerate

endmodule

// File: rtl/ternary_popcount_acc.sv
// Ternary neuron accumulator: sums popcount(pos) - popcount(neg) over a
// multi-beat frame, then reports the signed sum, a threshold fire bit and
// a sticky overflow flag. Stage 1 counts one beat, stage 2 accumulates,
// and a small FSM holds the result until downstream takes it.
module ternary_popcount_acc
    import tpc_pkg::*;
#(
    parameter int WIDTH   = 20,
    parameter int BEATS_W = 4,
    parameter int DROP    = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                cfg_approx,
    input  logic [acc_w(WIDTH, BEATS_W)-1:0]    cfg_thresh,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [WIDTH-1:0]                    in_pos,
    input  logic [WIDTH-1:0]                    in_neg,
    input  logic                                in_last,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [acc_w(WIDTH, BEATS_W)-1:0]    out_sum,
    output logic                                out_fire,
    output logic                                out_ovf
);

    localparam int CNT_W = cnt_w(WIDTH);
    localparam int ACC_W = acc_w(WIDTH, BEATS_W);
    localparam logic [BEATS_W-1:0] CNT_MAX = '1;

    state_e                    state;
    logic [BEATS_W-1:0]        beat_cnt;
    logic                      ovf;
    logic                      approx_q;
    logic signed [ACC_W-1:0]   thresh_q;
    logic signed [ACC_W-1:0]   acc;

    // vld_pipe[0]: stage-1 holds a beat; vld_pipe[1]: frame's last beat is in acc
    logic [1:0]                vld_pipe;
    logic signed [CNT_W:0]     s1_d;
    logic                      s1_last;
    logic                      s1_first;
    logic                      s1_skip;

    logic                      accept;
    logic                      res_take;
    logic                      first_beat;
    logic                      approx_eff;
    logic [WIDTH-1:0]          drop_mask;
    logic [WIDTH-1:0]          pos_m;
    logic [WIDTH-1:0]          neg_m;
    logic [CNT_W-1:0]          pos_cnt;
    logic [CNT_W-1:0]          neg_cnt;
    logic signed [CNT_W:0]     d_next;
    logic signed [ACC_W-1:0]   d_ext;

    assign accept     = in_valid & in_ready;
    assign res_take   = (state == HOLD) & out_ready;
    // Counter only returns to zero at result handshake, so zero means first beat.
    assign first_beat = (beat_cnt == '0);
    // First beat uses the live config; later beats use the latched copy.
    assign approx_eff = first_beat ? cfg_approx : approx_q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_mask
        assign drop_mask[i] = (i >= DROP);
    end

    assign pos_m = approx_eff ? (in_pos & drop_mask) : in_pos;
    assign neg_m = approx_eff ? (in_neg & drop_mask) : in_neg;

    popcount_tree #(.WIDTH(WIDTH)) u_pc_pos (.bits(pos_m), .cnt(pos_cnt));
    popcount_tree #(.WIDTH(WIDTH)) u_pc_neg (.bits(neg_m), .cnt(neg_cnt));

    assign d_next = $signed({1'b0, pos_cnt}) - $signed({1'b0, neg_cnt});
    assign d_ext  = {{(ACC_W-CNT_W-1){s1_d[CNT_W]}}, s1_d};

    // Frame bookkeeping: beat counter, sticky overflow, per-frame config latch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_cnt <= '0;
            ovf      <= 1'b0;
            approx_q <= 1'b0;
            thresh_q <= '0;
        end else if (res_take) begin
            beat_cnt <= '0;
            ovf      <= 1'b0;
        end else if (accept) begin
            if (first_beat) begin
                approx_q <= cfg_approx;
                thresh_q <= $signed(cfg_thresh);
            end
            if (!in_last) begin
                if (beat_cnt == CNT_MAX) ovf <= 1'b1;
                else                     beat_cnt <= beat_cnt + 1'b1;
            end
        end
    end

    // Stage 1: register the beat's signed count and its framing flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe[0] <= 1'b0;
            s1_d        <= '0;
            s1_last     <= 1'b0;
            s1_first    <= 1'b0;
            s1_skip     <= 1'b0;
        end else begin
            vld_pipe[0] <= accept;
            if (accept) begin
                s1_d     <= d_next;
                s1_last  <= in_last;
                s1_first <= first_beat;
                s1_skip  <= ovf;        // beats past the frame limit are dropped
            end
        end
    end

    // Stage 2: accumulate, loading fresh on a frame's first beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc         <= '0;
            vld_pipe[1] <= 1'b0;
        end else begin
            vld_pipe[1] <= vld_pipe[0] & s1_last;
            if (vld_pipe[0] && !s1_skip)
                acc <= s1_first ? d_ext : acc + d_ext;
            else if (res_take)
                acc <= '0;
        end
    end

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ACC;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_fire  <= 1'b0;
            out_ovf   <= 1'b0;
        end else begin
            case (state)
                ACC: begin
                    in_ready <= 1'b1;
                    if (accept && in_last) begin
                        state    <= FLUSH;
                        in_ready <= 1'b0;
                    end
                end
                FLUSH: begin
                    if (vld_pipe[1]) begin
                        state     <= HOLD;
                        out_valid <= 1'b1;
                        out_sum   <= acc;
                        out_fire  <= (acc >= thresh_q);
                        out_ovf   <= ovf;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state     <= ACC;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state    <= ACC;
                    in_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ternary_popcount_acc.sv
// Randomized bench for ternary_popcount_acc. Two instances run in lockstep
// (BEATS_W=4 and BEATS_W=2) and are compared against a frame-level model.
module tb_ternary_popcount_acc;

    localparam int WIDTH  = 20;
    localparam int DROP   = 4;
    localparam int ACC_W  = 10;   // cnt 5 + beats 4 + 1
    localparam int ACC_W2 = 8;    // cnt 5 + beats 2 + 1

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cfg_approx = 1'b0;
    logic [ACC_W-1:0]  cfg_thresh = '0;
    logic              in_valid = 1'b0;
    logic [WIDTH-1:0]  in_pos = '0;
    logic [WIDTH-1:0]  in_neg = '0;
    logic              in_last = 1'b0;
    logic              out_ready = 1'b0;

    logic              in_ready, out_valid, out_fire, out_ovf;
    logic [ACC_W-1:0]  out_sum;
    logic              in_ready2, out_valid2, out_fire2, out_ovf2;
    logic [ACC_W2-1:0] out_sum2;

    int n_tests = 0;
    int n_fail  = 0;

    logic [WIDTH-1:0] bp[$];
    logic [WIDTH-1:0] bn[$];

    always #5 clk = ~clk;

    ternary_popcount_acc #(.WIDTH(WIDTH), .BEATS_W(4), .DROP(DROP)) u_dut (
        .clk(clk), .rst(rst), .cfg_approx(cfg_approx), .cfg_thresh(cfg_thresh),
        .in_valid(in_valid), .in_ready(in_ready), .in_pos(in_pos), .in_neg(in_neg),
        .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_fire(out_fire), .out_ovf(out_ovf)
    );

    ternary_popcount_acc #(.WIDTH(WIDTH), .BEATS_W(2), .DROP(DROP)) u_dut_b2 (
        .clk(clk), .rst(rst), .cfg_approx(cfg_approx), .cfg_thresh(cfg_thresh[ACC_W2-1:0]),
        .in_valid(in_valid), .in_ready(in_ready2), .in_pos(in_pos), .in_neg(in_neg),
        .in_last(in_last), .out_valid(out_valid2), .out_ready(out_ready),
        .out_sum(out_sum2), .out_fire(out_fire2), .out_ovf(out_ovf2)
    );

    task automatic chk(input string tag, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Frame model: first 2^bw beats count, the rest are dropped.
    function automatic void model(input int bw, input bit approx, input int thresh,
                                  output int sum, output int fire, output int ovf);
        logic [WIDTH-1:0] m;
        int lim;
        m   = '1;
        lim = 1 << bw;
        if (approx) m = m << DROP;
        sum = 0;
        for (int i = 0; i < bp.size() && i < lim; i++)
            sum += $countones(bp[i] & m) - $countones(bn[i] & m);
        ovf  = (bp.size() > lim) ? 1 : 0;
        fire = (sum >= thresh) ? 1 : 0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold the current beat until accepted, then step past the accepting edge.
    task automatic push_beat();
        int k;
        k = 0;
        while (!in_ready && k < 20) begin
            tick();
            k++;
        end
        if (!in_ready) chk("accept_timeout", 0, 1);
        tick();
    endtask

    task automatic run_frame(input string name, input bit approx, input int thresh,
                             input int stall);
        int n, cyc, es, ef, eo, es2, ef2, eo2;
        n = bp.size();
        cfg_approx = approx;
        cfg_thresh = thresh[ACC_W-1:0];
        model(4, approx, thresh, es, ef, eo);
        model(2, approx, thresh, es2, ef2, eo2);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_pos   = bp[i];
            in_neg   = bn[i];
            in_last  = (i == n - 1);
            push_beat();
            if (i == 0) begin
                // later config changes must not affect this frame
                cfg_approx = ~approx;
                cfg_thresh = ACC_W'($urandom);
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk({name, ":busy"}, int'(in_ready), 0);
        cyc = 0;
        while (!out_valid && cyc < 10) begin
            tick();
            cyc++;
        end
        chk({name, ":latency"}, cyc, 2);
        chk({name, ":sum"},  int'($signed(out_sum)), es);
        chk({name, ":fire"}, int'(out_fire), ef);
        chk({name, ":ovf"},  int'(out_ovf), eo);
        chk({name, ":sum_b2"},  int'($signed(out_sum2)), es2);
        chk({name, ":fire_b2"}, int'(out_fire2), ef2);
        chk({name, ":ovf_b2"},  int'(out_ovf2), eo2);
        if (stall > 0) begin
            // offer a beat while stalled; it must not be taken
            in_valid = 1'b1;
            in_pos   = WIDTH'($urandom);
            in_neg   = WIDTH'($urandom);
            for (int s = 0; s < stall; s++) begin
                tick();
                chk({name, ":stall_valid"}, int'(out_valid), 1);
                chk({name, ":stall_sum"},   int'($signed(out_sum)), es);
                chk({name, ":stall_fire"},  int'(out_fire), ef);
                chk({name, ":stall_rdy"},   int'(in_ready), 0);
            end
            in_valid = 1'b0;
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({name, ":drop_valid"}, int'(out_valid), 0);
        chk({name, ":rdy_again"},  int'(in_ready), 1);
        bp.delete();
        bn.delete();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int nb;
        // reset state
        repeat (3) tick();
        chk("rst:in_ready",  int'(in_ready), 0);
        chk("rst:out_valid", int'(out_valid), 0);
        chk("rst:out_sum",   int'(out_sum), 0);
        chk("rst:out_fire",  int'(out_fire), 0);
        chk("rst:out_ovf",   int'(out_ovf), 0);
        rst = 1'b0;
        tick();
        chk("rst:ready_after", int'(in_ready), 1);

        // directed frames
        bp.push_back(20'hFFFFF); bn.push_back(20'h0000F);
        run_frame("exact1", 1'b0, 10, 0);
        bp.push_back(20'hFFFFF); bn.push_back(20'h0000F);
        run_frame("approx1", 1'b1, 10, 0);
        bp.push_back(20'h0000F); bn.push_back(20'h00000);
        run_frame("approx2", 1'b1, 1, 0);
        for (int t = 16; t <= 17; t++) begin
            bp.push_back(20'h0001F); bn.push_back(20'h00003);
            bp.push_back(20'h00000); bn.push_back(20'h0007F);
            bp.push_back(20'hFFFFF); bn.push_back(20'h00000);
            run_frame(t == 16 ? "three_t16" : "three_t17", 1'b0, t, 0);
        end
        for (int i = 0; i < 2; i++) begin
            bp.push_back(20'h00000); bn.push_back(20'hFFFFF);
        end
        run_frame("negative", 1'b0, 0, 0);
        bp.push_back(20'h00FFF); bn.push_back(20'h00003);
        run_frame("backpressure", 1'b0, 5, 5);
        for (int i = 0; i < 6; i++) begin
            bp.push_back(20'h00001); bn.push_back(20'h00000);
        end
        run_frame("ovf6", 1'b0, 3, 0);
        bp.push_back(20'h00007); bn.push_back(20'h00000);
        run_frame("after_ovf", 1'b0, 3, 0);
        for (int i = 0; i < 18; i++) begin
            bp.push_back(WIDTH'($urandom)); bn.push_back(WIDTH'($urandom));
        end
        run_frame("ovf18", 1'b0, 0, 0);

        // asynchronous reset mid-frame
        bp.push_back(20'h000FF); bn.push_back(20'h00000);
        run_frame("pre_reset", 1'b0, 0, 0);
        in_valid = 1'b1; in_pos = 20'hFFFFF; in_neg = '0; in_last = 1'b0;
        push_beat();
        push_beat();
        #3;
        rst = 1'b1;
        #1;
        chk("arst:in_ready",  int'(in_ready), 0);
        chk("arst:out_valid", int'(out_valid), 0);
        chk("arst:out_sum",   int'(out_sum), 0);
        chk("arst:out_fire",  int'(out_fire), 0);
        in_valid = 1'b0;
        tick();
        #2;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("arst:no_result", int'(out_valid), 0);
        end
        bp.push_back(20'h0F0F0); bn.push_back(20'h00101);
        run_frame("post_reset", 1'b0, 4, 0);

        // randomized frames, including mid-frame config churn and stalls
        for (int f = 0; f < 25; f++) begin
            nb = $urandom_range(1, 6);
            for (int i = 0; i < nb; i++) begin
                bp.push_back(WIDTH'($urandom)); bn.push_back(WIDTH'($urandom));
            end
            run_frame("rand", 1'($urandom_range(0, 1)), int'($urandom_range(0, 160)) - 80,
                      int'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
